trap_controller: RTL and testbench

TRAP_CONTROLLER -- requirements
Module: trap_controller

---
 rtl/trap_pkg.sv | 86 ++++++++
 rtl/trap_cause_mux.sv | 61 ++++++
 rtl/trap_controller.sv | 175 +++++++++++++++++
 tb/tb_trap_controller.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// trap_pkg -- shared definitions for the trap controller slice.
//
// Holds the FSM state encoding, the mtval source-select constants and a
// helper that maps an exception code onto its mtval source.
// Exception codes and privilege encodings normally come from
// riscv_defines.vh. The guarded defaults below use the same RISC-V values
// so this slice also builds standalone.
// Build macro: TRAP_MTVAL_EN (mtval formation; see trap_controller.sv).

`ifndef XLEN_32b
  `define XLEN_32b 1
`endif
`ifndef XLEN_64b
  `define XLEN_64b 2
`endif
`ifndef NO_E
  `define NO_E 4'hF
`endif
`ifndef E_INSTR_MISALIGNED
  `define E_INSTR_MISALIGNED 4'd0
`endif
`ifndef E_INSTR_FAULT
  `define E_INSTR_FAULT 4'd1
`endif
`ifndef E_ILLEGAL_INSTR
  `define E_ILLEGAL_INSTR 4'd2
`endif
`ifndef E_BREAKPOINT
  `define E_BREAKPOINT 4'd3
`endif
`ifndef E_LOAD_MISALIGNED
  `define E_LOAD_MISALIGNED 4'd4
`endif
`ifndef E_LOAD_FAULT
  `define E_LOAD_FAULT 4'd5
`endif
`ifndef E_STORE_MISALIGNED
  `define E_STORE_MISALIGNED 4'd6
`endif
`ifndef E_STORE_FAULT
  `define E_STORE_FAULT 4'd7
`endif
`ifndef E_ECALL
  `define E_ECALL 4'd11
`endif
`ifndef USER
  `define USER 2'b00
`endif
`ifndef SUPERVISOR
  `define SUPERVISOR 2'b01
`endif
`ifndef MACHINE
  `define MACHINE 2'b11
`endif

package trap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CAPTURE  = 3'd1,
    ST_REDIRECT = 3'd2,
    ST_MRET     = 3'd3,
    ST_SETTLE   = 3'd4
  } trap_state_e;

  typedef enum logic [1:0] {
    MTVAL_SRC_ZERO  = 2'd0,
    MTVAL_SRC_PC_F  = 2'd1,
    MTVAL_SRC_INSTR = 2'd2,
    MTVAL_SRC_ADDR  = 2'd3
  } mtval_src_e;

  // Which datapath value the trap reports in mtval for a given cause.
  function automatic mtval_src_e mtval_src(input logic [3:0] code);
    case (code)
      `E_INSTR_MISALIGNED: return MTVAL_SRC_PC_F;
      `E_ILLEGAL_INSTR:    return MTVAL_SRC_INSTR;
      `E_LOAD_MISALIGNED,
      `E_LOAD_FAULT,
      `E_STORE_MISALIGNED,
      `E_STORE_FAULT:      return MTVAL_SRC_ADDR;
      default:             return MTVAL_SRC_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/trap_cause_mux.sv
// trap_cause_mux -- combinational trap selection and CSR value formation.
//
// Ports:
//   i_exception_code_f/e  fetch / execute exception codes (`NO_E = none)
//   i_mret_e              MRET in execute
//   i_pc_f / i_pc_e       PCs of the F / E instructions
//   i_instr_f, i_alu_out_e  mtval sources (present only with TRAP_MTVAL_EN)
//   o_take_exc / o_take_mret  selected event (E exc > MRET > F exc)
//   o_mcause, o_mepc, o_mtval  values for the selected exception
// Build macro: TRAP_MTVAL_EN adds the mtval inputs and output.

module trap_cause_mux
  import trap_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [3:0]   i_exception_code_f,
  input  logic [3:0]   i_exception_code_e,
  input  logic         i_mret_e,
  input  logic [W-1:0] i_pc_f,
  input  logic [W-1:0] i_pc_e,
`ifdef TRAP_MTVAL_EN
  input  logic [31:0]  i_instr_f,
  input  logic [W-1:0] i_alu_out_e,
  output logic [W-1:0] o_mtval,
`endif
  output logic         o_take_exc,
  output logic         o_take_mret,
  output logic [W-1:0] o_mcause,
  output logic [W-1:0] o_mepc
);

  logic       exc_e;
  logic       exc_f;
  logic [3:0] sel_code;

  assign exc_e = (i_exception_code_e != `NO_E);
  assign exc_f = (i_exception_code_f != `NO_E);

  // An E-stage trap masks MRET; MRET masks a younger F-stage trap.
  assign o_take_exc  = exc_e | (exc_f & ~i_mret_e);
  assign o_take_mret = ~exc_e & i_mret_e;

  assign sel_code = exc_e ? i_exception_code_e : i_exception_code_f;
  // Exceptions only: the interrupt bit (W-1) is always zero here.
  assign o_mcause = {{(W-4){1'b0}}, sel_code};
  assign o_mepc   = exc_e ? i_pc_e : i_pc_f;

`ifdef TRAP_MTVAL_EN
  always_comb begin
    o_mtval = '0;
    case (mtval_src(sel_code))
      MTVAL_SRC_PC_F:  o_mtval = i_pc_f;
      MTVAL_SRC_INSTR: o_mtval = {{(W-32){1'b0}}, i_instr_f};
      MTVAL_SRC_ADDR:  o_mtval = i_alu_out_e;
      default:         o_mtval = '0;
    endcase
  end
`endif

endmodule

// File: rtl/trap_controller.sv
// trap_controller -- sequences exception entry and MRET return.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_exception_code_f/e    F / E exception codes (`NO_E = none)
//   i_pc_f, i_pc_e, i_instr_f, i_alu_out_e  trap context
//   i_mret_e                MRET in execute
//   i_current_privilege, i_mstatus_mpp, i_mtvec, i_mepc  CSR state
//   o_flush_f/d/e           kill stage contents (combinational, IDLE only)
//   o_stall_f               freeze PC during CAPTURE / REDIRECT / MRET
//   o_csr_we + o_mcause/o_mepc/o_mtval/o_mpp_save  CSR update
//   o_priv_we + o_new_privilege  privilege update
//   o_redirect_valid + o_redirect_pc  PC override
//   o_disable_exceptions_1cc  exception mask for the settle cycle
//   o_busy                  FSM not in IDLE
//   o_fsm_state             FSM state for observation
// Build macro: TRAP_MTVAL_EN -- when undefined o_mtval is tied to zero and
// no tval register exists.
//
// Handshake: there is no backpressure. Events are sampled only in IDLE and
// are dropped otherwise; every strobe (csr_we, priv_we, redirect_valid,
// disable_exceptions_1cc) is a single-cycle pulse that consumers must take
// in the cycle it is high. Data outputs are only meaningful with their
// strobe.

module trap_controller
  import trap_pkg::*;
#(
  parameter int  XLEN = `XLEN_64b,
  localparam int W    = 1 << (XLEN + 4)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [3:0]   i_exception_code_f,
  input  logic [3:0]   i_exception_code_e,
  input  logic [W-1:0] i_pc_f,
  input  logic [W-1:0] i_pc_e,
  input  logic [31:0]  i_instr_f,
  input  logic [W-1:0] i_alu_out_e,
  input  logic         i_mret_e,
  input  logic [1:0]   i_current_privilege,
  input  logic [1:0]   i_mstatus_mpp,
  input  logic [W-1:0] i_mtvec,
  input  logic [W-1:0] i_mepc,
  output logic         o_flush_f,
  output logic         o_flush_d,
  output logic         o_flush_e,
  output logic         o_stall_f,
  output logic         o_csr_we,
  output logic [W-1:0] o_mcause,
  output logic [W-1:0] o_mepc,
  output logic [W-1:0] o_mtval,
  output logic [1:0]   o_mpp_save,
  output logic         o_priv_we,
  output logic [1:0]   o_new_privilege,
  output logic         o_redirect_valid,
  output logic [W-1:0] o_redirect_pc,
  output logic         o_disable_exceptions_1cc,
  output logic         o_busy,
  output logic [2:0]   o_fsm_state
);

  trap_state_e  state_q;
  logic         take_exc;
  logic         take_mret;
  logic         accept;
  logic [W-1:0] mcause_sel;
  logic [W-1:0] mepc_sel;

`ifdef TRAP_MTVAL_EN
  logic [W-1:0] mtval_sel;
  logic [W-1:0] tval_q;
`endif

  trap_cause_mux #(.W(W)) u_cause_mux (
    .i_exception_code_f (i_exception_code_f),
    .i_exception_code_e (i_exception_code_e),
    .i_mret_e           (i_mret_e),
    .i_pc_f             (i_pc_f),
    .i_pc_e             (i_pc_e),
`ifdef TRAP_MTVAL_EN
    .i_instr_f          (i_instr_f),
    .i_alu_out_e        (i_alu_out_e),
    .o_mtval            (mtval_sel),
`endif
    .o_take_exc         (take_exc),
    .o_take_mret        (take_mret),
    .o_mcause           (mcause_sel),
    .o_mepc             (mepc_sel)
  );

  // Flushes are gated by reset so every output is low while it is held.
  assign accept    = i_rst_n & (state_q == ST_IDLE);
  assign o_flush_f = accept & (take_exc | take_mret);
  assign o_flush_d = accept & (take_exc | take_mret);
  assign o_flush_e = accept & take_exc;

  assign o_stall_f   = (state_q == ST_CAPTURE) | (state_q == ST_REDIRECT) |
                       (state_q == ST_MRET);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_fsm_state = state_q;

  // Strobes are registered one cycle ahead so each lands in the state that
  // owns it; data registers simply hold until the next accepted event.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q                  <= ST_IDLE;
      o_csr_we                 <= 1'b0;
      o_mcause                 <= '0;
      o_mepc                   <= '0;
      o_mpp_save               <= 2'b00;
      o_priv_we                <= 1'b0;
      o_new_privilege          <= 2'b00;
      o_redirect_valid         <= 1'b0;
      o_redirect_pc            <= '0;
      o_disable_exceptions_1cc <= 1'b0;
    end else begin
      o_csr_we                 <= 1'b0;
      o_priv_we                <= 1'b0;
      o_redirect_valid         <= 1'b0;
      o_disable_exceptions_1cc <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (take_exc) begin
            state_q         <= ST_CAPTURE;
            o_mcause        <= mcause_sel;
            o_mepc          <= mepc_sel;
            o_mpp_save      <= i_current_privilege;
            o_new_privilege <= `MACHINE;
            o_csr_we        <= 1'b1;
            o_priv_we       <= 1'b1;
          end else if (take_mret) begin
            state_q          <= ST_MRET;
            o_redirect_pc    <= i_mepc;
            o_new_privilege  <= i_mstatus_mpp;
            o_redirect_valid <= 1'b1;
            o_priv_we        <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          state_q          <= ST_REDIRECT;
          // Direct mode only: the mode field in mtvec[1:0] is dropped.
          o_redirect_pc    <= {i_mtvec[W-1:2], 2'b00};
          o_redirect_valid <= 1'b1;
        end
        ST_REDIRECT, ST_MRET: begin
          state_q                  <= ST_SETTLE;
          o_disable_exceptions_1cc <= 1'b1;
        end
        ST_SETTLE: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef TRAP_MTVAL_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tval_q <= '0;
    end else if ((state_q == ST_IDLE) && take_exc) begin
      tval_q <= mtval_sel;
    end
  end
  assign o_mtval = tval_q;

  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^i_mtvec[1:0];
`else
  assign o_mtval = '0;

  logic unused_tval_inputs;
  assign unused_tval_inputs = ^{i_instr_f, i_alu_out_e, i_mtvec[1:0]};
`endif

endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller -- directed bench for trap_controller.
// Expected strobe cycles are queued by the stimulus and consumed by a
// negedge monitor that compares every cycle in which a strobe is high.

module tb_trap_controller;
  import trap_pkg::*;

  localparam int W = 64;

  logic         clk;
  logic         rst_n;
  logic [3:0]   exc_f, exc_e;
  logic [W-1:0] pc_f, pc_e, alu_out_e, mtvec, mepc;
  logic [31:0]  instr_f;
  logic         mret_e;
  logic [1:0]   cur_priv, mpp;

  logic         flush_f, flush_d, flush_e, stall_f, csr_we, priv_we;
  logic         redirect_valid, dis_1cc, busy;
  logic [W-1:0] mcause, mepc_o, mtval, redirect_pc;
  logic [1:0]   mpp_save, new_priv;
  logic [2:0]   fsm_state;

  trap_controller #(.XLEN(`XLEN_64b)) dut (
    .i_clk                    (clk),
    .i_rst_n                  (rst_n),
    .i_exception_code_f       (exc_f),
    .i_exception_code_e       (exc_e),
    .i_pc_f                   (pc_f),
    .i_pc_e                   (pc_e),
    .i_instr_f                (instr_f),
    .i_alu_out_e              (alu_out_e),
    .i_mret_e                 (mret_e),
    .i_current_privilege      (cur_priv),
    .i_mstatus_mpp            (mpp),
    .i_mtvec                  (mtvec),
    .i_mepc                   (mepc),
    .o_flush_f                (flush_f),
    .o_flush_d                (flush_d),
    .o_flush_e                (flush_e),
    .o_stall_f                (stall_f),
    .o_csr_we                 (csr_we),
    .o_mcause                 (mcause),
    .o_mepc                   (mepc_o),
    .o_mtval                  (mtval),
    .o_mpp_save               (mpp_save),
    .o_priv_we                (priv_we),
    .o_new_privilege          (new_priv),
    .o_redirect_valid         (redirect_valid),
    .o_redirect_pc            (redirect_pc),
    .o_disable_exceptions_1cc (dis_1cc),
    .o_busy                   (busy),
    .o_fsm_state              (fsm_state)
  );

  typedef struct packed {
    logic [31:0]  cyc;
    logic         csr_we;
    logic         priv_we;
    logic         rv;
    logic         dis;
    logic [W-1:0] mcause;
    logic [W-1:0] mepc;
    logic [W-1:0] mtval;
    logic [1:0]   mpp;
    logic [1:0]   np;
    logic [W-1:0] rpc;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  passes = 0;
  int  cyc = 0;
  int  last_redir = -100;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  function automatic logic [W-1:0] exp_tval(input logic [W-1:0] v);
`ifdef TRAP_MTVAL_EN
    return v;
`else
    return '0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    exc_f  = `NO_E;
    exc_e  = `NO_E;
    mret_e = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 12; i++) begin
      if (!busy) break;
      step();
    end
    check({name, "_idle"}, busy, 1'b0);
    check({name, "_stall_idle"}, stall_f, 1'b0);
  endtask

  // Inputs for an exception are already applied in the current cycle N.
  task automatic fire_exc(input string name, input logic [W-1:0] cause,
                          input logic [W-1:0] epc, input logic [W-1:0] tval,
                          input logic [1:0] priv);
    ev_t e;
    int  n;
    n = cyc;
    e = '0; e.cyc = n + 1; e.csr_we = 1'b1; e.priv_we = 1'b1;
    e.mcause = cause; e.mepc = epc; e.mtval = exp_tval(tval);
    e.mpp = priv; e.np = `MACHINE;
    exp_q.push_back(e);
    e = '0; e.cyc = n + 2; e.rv = 1'b1; e.rpc = {mtvec[W-1:2], 2'b00};
    exp_q.push_back(e);
    e = '0; e.cyc = n + 3; e.dis = 1'b1;
    exp_q.push_back(e);
    #1;
    check({name, "_flush"}, {flush_f, flush_d, flush_e}, 3'b111);
    step();
    idle_inputs();
    check({name, "_capture_stall_busy"}, {stall_f, busy}, 2'b11);
    wait_idle(name);
  endtask

  task automatic fire_mret(input string name, input logic [1:0] np, input logic [W-1:0] rpc);
    ev_t e;
    int  n;
    n = cyc;
    e = '0; e.cyc = n + 1; e.priv_we = 1'b1; e.rv = 1'b1; e.np = np; e.rpc = rpc;
    exp_q.push_back(e);
    e = '0; e.cyc = n + 2; e.dis = 1'b1;
    exp_q.push_back(e);
    #1;
    check({name, "_flush"}, {flush_f, flush_d, flush_e}, 3'b110);
    step();
    idle_inputs();
    check({name, "_mret_stall_busy"}, {stall_f, busy}, 2'b11);
    wait_idle(name);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    ev_t obs;
    ev_t e;
    if (csr_we | priv_we | redirect_valid | dis_1cc) begin
      obs = '0;
      obs.cyc = cyc; obs.csr_we = csr_we; obs.priv_we = priv_we;
      obs.rv = redirect_valid; obs.dis = dis_1cc;
      if (csr_we) begin
        obs.mcause = mcause; obs.mepc = mepc_o; obs.mtval = mtval; obs.mpp = mpp_save;
      end
      if (priv_we) obs.np = new_priv;
      if (redirect_valid) obs.rpc = redirect_pc;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_event cyc=%0d got=%0h exp=none", cyc, obs);
      end else begin
        e = exp_q.pop_front();
        if (obs === e) passes++;
        else $display("FAIL event_cyc%0d got=%0h exp=%0h", e.cyc, obs, e);
      end
    end
    if (redirect_valid) begin
      checks++;
      if (cyc - last_redir >= 3) passes++;
      else $display("FAIL redirect_spacing got=%0d exp>=3", cyc - last_redir);
      last_redir = cyc;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    idle_inputs();
    pc_f = '0; pc_e = '0; instr_f = '0; alu_out_e = '0;
    cur_priv = `MACHINE; mpp = `USER;
    mtvec = 64'h8000_0001; mepc = '0;
    exc_e = `E_ECALL;  // present during reset: must not flush
    repeat (3) step();
    check("reset_outputs",
          {flush_f, flush_d, flush_e, stall_f, csr_we, mcause, mepc_o, mtval, mpp_save,
           priv_we, new_priv, redirect_valid, redirect_pc, dis_1cc, busy},
          '0);
    check("reset_state", fsm_state, 3'd0);
    idle_inputs();
    rst_n = 1'b1;
    repeat (2) step();

    // ecall from E
    exc_e = `E_ECALL; pc_e = 64'h100; cur_priv = `MACHINE;
    fire_exc("ecall", 64'd11, 64'h100, 64'h0, `MACHINE);

    // E load misaligned wins over simultaneous F illegal
    exc_e = `E_LOAD_MISALIGNED; alu_out_e = 64'h2003; pc_e = 64'h300;
    exc_f = `E_ILLEGAL_INSTR; instr_f = 32'hFFFF_FFFF; pc_f = 64'h304;
    fire_exc("load_misal", 64'd4, 64'h300, 64'h2003, `MACHINE);

    // F illegal from user mode
    exc_f = `E_ILLEGAL_INSTR; instr_f = 32'hFFFF_FFFF; pc_f = 64'h40; cur_priv = `USER;
    fire_exc("f_illegal", 64'd2, 64'h40, 64'hFFFF_FFFF, `USER);

    // MRET back to user
    mret_e = 1'b1; mepc = 64'h200; mpp = `USER;
    fire_mret("mret_u", `USER, 64'h200);

    // store fault, mtvec mode bits set
    mtvec = 64'h1237; cur_priv = `SUPERVISOR;
    exc_e = `E_STORE_FAULT; alu_out_e = 64'h1000; pc_e = 64'h500;
    fire_exc("store_fault", 64'd7, 64'h500, 64'h1000, `SUPERVISOR);

    // MRET beats F exception
    mret_e = 1'b1; mepc = 64'h240; mpp = `SUPERVISOR;
    exc_f = `E_ILLEGAL_INSTR; pc_f = 64'h700;
    fire_mret("mret_over_f", `SUPERVISOR, 64'h240);

    // E exception beats MRET
    mret_e = 1'b1; exc_e = `E_LOAD_FAULT; alu_out_e = 64'h5555; pc_e = 64'h800;
    fire_exc("e_over_mret", 64'd5, 64'h800, 64'h5555, `SUPERVISOR);

    // second event during CAPTURE ignored; reset in REDIRECT aborts
    mtvec = 64'h8000_0001; cur_priv = `MACHINE;
    exc_e = `E_STORE_MISALIGNED; alu_out_e = 64'h3001; pc_e = 64'h600;
    begin
      ev_t e;
      e = '0; e.cyc = cyc + 1; e.csr_we = 1'b1; e.priv_we = 1'b1;
      e.mcause = 64'd6; e.mepc = 64'h600; e.mtval = exp_tval(64'h3001);
      e.mpp = `MACHINE; e.np = `MACHINE;
      exp_q.push_back(e);
    end
    #1;
    check("abort_flush", {flush_f, flush_d, flush_e}, 3'b111);
    step();
    exc_e = `E_LOAD_FAULT; exc_f = `E_ILLEGAL_INSTR; mret_e = 1'b1;
    #1;
    check("capture_ignores_event", {flush_f, flush_d, flush_e, fsm_state}, {3'b000, 3'd1});
    step();
    idle_inputs();
    check("in_redirect_state", fsm_state, 3'd2);
    rst_n = 1'b0;
    #1;
    check("reset_in_redirect_outputs",
          {flush_f, flush_d, flush_e, stall_f, csr_we, mcause, mepc_o, mtval, mpp_save,
           priv_we, new_priv, redirect_valid, redirect_pc, dis_1cc, busy},
          '0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (5) step();
    check("after_reset_idle", {busy, fsm_state}, 4'd0);

    // fetch misaligned after recovery
    exc_f = `E_INSTR_MISALIGNED; pc_f = 64'h42; cur_priv = `USER;
    fire_exc("fetch_misal", 64'd0, 64'h42, 64'h42, `USER);

    repeat (4) step();
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
